// File: rtl/alu_pkg.sv
// Shared types for alu_pipe: opcode map, FSM states and the status-flag bundle.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOTA = 4'd5,
      OP_NOTB = 4'd6,
      OP_EQ   = 4'd7,
      OP_SHL  = 4'd8,
      OP_SHR  = 4'd9,
      OP_SRA  = 4'd10,
      OP_SLT  = 4'd11,
      OP_MUL  = 4'd12
   } opcode_e;

   // Opcodes in this range always return err; OP_MUL joins them when the multiplier is absent.
   localparam logic [3:0] OP_ILLEGAL_LO = 4'd13;
   localparam logic [3:0] OP_ILLEGAL_HI = 4'd15;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

   typedef struct packed {
      logic carry;
      logic zero;
      logic ovf;
      logic err;
   } flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand-issue and result-consumer handshake bundle for alu_pipe.
interface alu_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             ovf;
   logic             err;

   modport master (
      output in_valid, opcode, a, b, out_ready,
      input  in_ready, out_valid, result, carry, zero, ovf, err
   );

   modport slave (
      input  in_valid, opcode, a, b, out_ready,
      output in_ready, out_valid, result, carry, zero, ovf, err
   );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: low WIDTH bits of a*b, WIDTH cycles from start to done.
module alu_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;

   // The start edge already folds in partial product 0, so the last one lands
   // one cycle early and the caller can load its output on the WIDTH-th edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (start_i) begin
         acc_q    <= a_i & {WIDTH{b_i[0]}};
         mcand_q  <= a_i << 1;
         mplier_q <= b_i >> 1;
         cnt_q    <= CW'(WIDTH - 1);
         busy_q   <= 1'b1;
         done_q   <= 1'b0;
      end else if (busy_q) begin
         if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
         end
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign product_o = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides. Define ALU_MUL_EN to build in the
// multi-cycle multiplier (opcode 12); otherwise opcode 12 is illegal.
//
// state   | meaning
// ST_IDLE | accepting operations; single-cycle ops load the output register directly
// ST_MUL  | multiply in flight; in_ready low until the product is loaded
module alu_pipe
   import alu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_pipe_if.slave bus
);
   localparam int MSB = WIDTH - 1;

   if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("alu_pipe: WIDTH must be a power of two and at least 8");
   end

   logic [WIDTH-1:0] result_q;
   flags_t           flags_q;
   logic             out_valid_q;

   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   dif_w;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] res_c;
   flags_t           flg_c;
   logic             in_ready_c;
   logic             accept;

   assign sum_w = {1'b0, bus.a} + {1'b0, bus.b};
   assign dif_w = {1'b0, bus.a} - {1'b0, bus.b};
   assign shamt = bus.b[SHW-1:0];

   always_comb begin
      res_c = '0;
      flg_c = '0;
      case (bus.opcode)
         OP_ADD: begin
            res_c       = sum_w[WIDTH-1:0];
            flg_c.carry = sum_w[WIDTH];
            flg_c.ovf   = (bus.a[MSB] == bus.b[MSB]) && (sum_w[MSB] != bus.a[MSB]);
         end
         OP_SUB: begin
            res_c       = dif_w[WIDTH-1:0];
            flg_c.carry = dif_w[WIDTH];
            flg_c.ovf   = (bus.a[MSB] != bus.b[MSB]) && (dif_w[MSB] != bus.a[MSB]);
         end
         OP_AND:  res_c = bus.a & bus.b;
         OP_OR:   res_c = bus.a | bus.b;
         OP_XOR:  res_c = bus.a ^ bus.b;
         OP_NOTA: res_c = ~bus.a;
         OP_NOTB: res_c = ~bus.b;
         OP_EQ:   res_c = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
         OP_SHL:  res_c = bus.a << shamt;
         OP_SHR:  res_c = bus.a >> shamt;
         OP_SRA:  res_c = $signed(bus.a) >>> shamt;
         OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
         // OP_MUL never loads through this path; without the multiplier it is illegal.
         default: flg_c.err = 1'b1;
      endcase
      flg_c.zero = (res_c == '0);
   end

`ifdef ALU_MUL_EN
   state_e           state_q;
   logic             is_mul;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic             mul_load;
   logic [WIDTH-1:0] mul_prod;
   flags_t           mul_flg;

   assign is_mul     = (bus.opcode == OP_MUL);
   assign in_ready_c = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
   assign accept     = bus.in_valid && in_ready_c;
   assign mul_start  = accept && is_mul;
   assign mul_load   = (state_q == ST_MUL) && mul_done && !mul_busy &&
                       (!out_valid_q || bus.out_ready);
   assign mul_flg    = '{carry: 1'b0, zero: (mul_prod == '0), ovf: 1'b0, err: 1'b0};

   alu_mul_seq #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (mul_start),
      .a_i      (bus.a),
      .b_i      (bus.b),
      .busy_o   (mul_busy),
      .done_o   (mul_done),
      .product_o(mul_prod)
   );
`else
   assign in_ready_c = !out_valid_q || bus.out_ready;
   assign accept     = bus.in_valid && in_ready_c;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
`ifdef ALU_MUL_EN
         state_q     <= ST_IDLE;
`endif
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         // Retire first; a load in the same cycle overrides and keeps out_valid high.
         if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
`ifdef ALU_MUL_EN
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state_q <= ST_MUL;
                  end else begin
                     result_q    <= res_c;
                     flags_q     <= flg_c;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               if (mul_load) begin
                  result_q    <= mul_prod;
                  flags_q     <= mul_flg;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
`else
         if (accept) begin
            result_q    <= res_c;
            flags_q     <= flg_c;
            out_valid_q <= 1'b1;
         end
`endif
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.carry     = flags_q.carry;
   assign bus.zero      = flags_q.zero;
   assign bus.ovf       = flags_q.ovf;
   assign bus.err       = flags_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=32): fixed vectors, directed handshake/multiply sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_alu_pipe;
   import alu_pkg::*;

   localparam int W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(W)) bus ();

   alu_pipe #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        c, z, o, e;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        c, z, o, e;
   } exp_t;

   int   tests = 0;
   int   fails = 0;
   exp_t sb_q[$];
   vec_t vecs[$];
   logic mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic c, input logic z,
                          input logic o, input logic e);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res;
      v.c = c; v.z = z; v.o = o; v.e = e;
      vecs.push_back(v);
   endtask

   // Reference: plain 64-bit arithmetic on the operand values.
   function automatic exp_t ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t               r;
      longint unsigned    ua  = 64'(a);
      longint unsigned    ub  = 64'(b);
      longint             sa  = longint'($signed(a));
      longint             sbv = longint'($signed(b));
      longint             s;
      logic signed [31:0] t;
      int                 sh  = int'(b[4:0]);
      r.res = '0; r.c = 1'b0; r.o = 1'b0; r.e = 1'b0;
      case (op)
         4'd0: begin
            r.res = 32'(ua + ub);
            r.c   = (ua + ub) > 64'hFFFF_FFFF;
            s = sa + sbv; t = 32'(s); r.o = (longint'(t) != s);
         end
         4'd1: begin
            r.res = 32'(ua - ub);
            r.c   = ua < ub;
            s = sa - sbv; t = 32'(s); r.o = (longint'(t) != s);
         end
         4'd2:  r.res = a & b;
         4'd3:  r.res = a | b;
         4'd4:  r.res = a ^ b;
         4'd5:  r.res = ~a;
         4'd6:  r.res = ~b;
         4'd7:  r.res = (a == b) ? 32'd1 : 32'd0;
         4'd8:  r.res = 32'(ua << sh);
         4'd9:  r.res = 32'(ua >> sh);
         4'd10: r.res = 32'(sa >>> sh);
         4'd11: r.res = (sa < sbv) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
         4'd12: r.res = 32'(ua * ub);
`endif
         default: r.e = 1'b1;
      endcase
      r.z = (r.res == 32'd0);
      return r;
   endfunction

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 4))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard: every accepted op must come out once, in order, with model values.
   always @(negedge clk) begin
      exp_t ex;
      if (mon_en && rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL sb_extra: got result 0x%0h, expected no pending result", bus.result);
            end else begin
               ex = sb_q.pop_front();
               chk("sb_result", bus.result, ex.res);
               chk("sb_flags", 32'({bus.carry, bus.zero, bus.ovf, bus.err}),
                   32'({ex.c, ex.z, ex.o, ex.e}));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(ref_alu(bus.opcode, bus.a, bus.b));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int rdy_hi;
      int ov_hi;

      bus.in_valid  = 1'b0;
      bus.opcode    = 4'd0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;

      #3;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_flags", 32'({bus.carry, bus.zero, bus.ovf, bus.err}), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      #19 rst_n = 1'b1;
      step();
      mon_en = 1'b1;

      //       op     a             b             result        c     z     o     e
      add_vec(4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
      add_vec(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
      add_vec(4'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
      add_vec(4'd1,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
      add_vec(4'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      add_vec(4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1'b0);
      add_vec(4'd3,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
      add_vec(4'd4,  32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
      add_vec(4'd5,  32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      add_vec(4'd6,  32'h0000_0000, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      add_vec(4'd7,  32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
      add_vec(4'd7,  32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      add_vec(4'd8,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
      add_vec(4'd9,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
      add_vec(4'd10, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      add_vec(4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
      add_vec(4'd11, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      add_vec(4'd13, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
      add_vec(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
      add_vec(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
`ifndef ALU_MUL_EN
      add_vec(4'd12, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
`endif

      foreach (vecs[i]) begin
         bus.opcode    = vecs[i].op;
         bus.a         = vecs[i].a;
         bus.b         = vecs[i].b;
         bus.in_valid  = 1'b1;
         bus.out_ready = 1'b1;
         step();
         bus.in_valid = 1'b0;
         chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
         chk($sformatf("vec%0d_result", i), bus.result, vecs[i].res);
         chk($sformatf("vec%0d_flags", i), 32'({bus.carry, bus.zero, bus.ovf, bus.err}),
             32'({vecs[i].c, vecs[i].z, vecs[i].o, vecs[i].e}));
         step();
         chk($sformatf("vec%0d_retired", i), 32'(bus.out_valid), 32'd0);
      end

      // Backpressure: first result must hold while the consumer stalls.
      bus.out_ready = 1'b0;
      bus.opcode    = 4'd0;
      bus.a         = 32'd1;
      bus.b         = 32'd1;
      bus.in_valid  = 1'b1;
      step();
      bus.a = 32'd2;
      bus.b = 32'd2;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_hold_result", bus.result, 32'd2);
         chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
      step();
      chk("bp_second_result", bus.result, 32'd4);
      for (int k = 0; k < 8; k++) begin
         bus.a = 32'(k + 10);
         bus.b = 32'(k);
         #1;
         chk("tput_in_ready", 32'(bus.in_ready), 32'd1);
         step();
         chk("tput_result", bus.result, 32'(2 * k + 10));
         chk("tput_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid = 1'b0;
      step();
      chk("tput_drained", 32'(bus.out_valid), 32'd0);

`ifdef ALU_MUL_EN
      bus.opcode   = 4'd12;
      bus.a        = 32'h0000_FFFF;
      bus.b        = 32'h0001_0001;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      lat = 0; rdy_hi = 0;
      while (!bus.out_valid && lat < 100) begin
         if (bus.in_ready) rdy_hi++;
         step();
         lat++;
      end
      chk("mul_latency", 32'(lat), 32'd32);
      chk("mul_in_ready_low", 32'(rdy_hi), 32'd0);
      chk("mul_result", bus.result, 32'hFFFF_FFFF);
      chk("mul_flags", 32'({bus.carry, bus.zero, bus.ovf, bus.err}), 32'd0);
      step();

      bus.opcode   = 4'd12;
      bus.a        = 32'h1234_5678;
      bus.b        = 32'h0000_0003;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      repeat (10) step();
      #2 rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      ov_hi = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (bus.out_valid) ov_hi++;
      end
      chk("abort_no_result", 32'(ov_hi), 32'd0);
      chk("abort_idle_ready", 32'(bus.in_ready), 32'd1);
`endif

      for (int cyc = 0; cyc < 600; cyc++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.opcode    = 4'($urandom_range(0, 15));
         bus.a         = rnd_opnd();
         bus.b         = rnd_opnd();
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (40) step();
      chk("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
